clk_div_ctrl: RTL
=================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: divide counter width; legal select range 0..CNT_W-1.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 run  input  1  level; 1 requests divided-clock generation, 0 requests graceful stop.
REQ-005 cfg_valid  input  1  ratio-change request.
REQ-006 cfg_sel  input  3  requested ratio: divide by 2^(cfg_sel+1).
REQ-007 cfg_ready  output  1  controller can accept a request this cycle.
REQ-008 clk_en  output  1  one-cycle enable pulse, once per divided period.
REQ-009 clk_out  output  1  50%-duty divided clock, registered.
REQ-010 cur_sel  output  3  select currently in effect.
REQ-011 busy  output  1  ratio change or stop pending.
REQ-012 err  output  1  sticky flag for illegal cfg_sel.

Function
REQ-013 FSM states: IDLE, RUN, SWITCH, STOP; the state encoding comes from the shared package.
REQ-014 cnt is a CNT_W-bit register; N = 2^(cur_sel+1); terminal = (cnt[cur_sel:0] all ones).
REQ-015 IDLE: cnt held at 0, clk_en=0, clk_out=0; run=1 -> RUN next edge with cnt=0.
REQ-016 RUN/SWITCH/STOP: cnt increments by 1 each cycle and wraps modulo 2^CNT_W.
REQ-017 clk_en is a flop output equal to 1 exactly during cycles where terminal holds; first pulse is in the Nth cycle of RUN.
REQ-018 clk_out is a flop output equal to cnt[cur_sel]: low for N/2 cycles, then high for N/2 cycles.
REQ-019 cfg_ready = 1 in IDLE and RUN, and 0 in SWITCH and STOP; handshake completes when cfg_valid and cfg_ready are both 1 on a clock edge.
REQ-020 Accepted cfg_sel >= CNT_W: err set, request discarded, state unchanged.
REQ-021 Accepted legal cfg_sel in IDLE: cur_sel updates at the next edge.
REQ-022 Accepted legal cfg_sel in RUN: value stored as pending, state -> SWITCH, busy=1.
REQ-023 SWITCH: on the edge ending a terminal cycle, cur_sel <= pending and cnt <= 0, then state -> RUN, or -> IDLE if run=0; this gives no runt pulse on clk_out.
REQ-024 Request accepted in a RUN cycle that is itself terminal: the switch waits for the next full period; the current terminal is not used.
REQ-025 run=0 in RUN: state -> STOP, busy=1; on the edge ending the next terminal cycle, state -> IDLE and cnt <= 0.
REQ-026 run returns to 1 while in STOP: stop still completes to IDLE; RUN is re-entered on the following edge.
REQ-027 busy = 1 in SWITCH and STOP, 0 otherwise.
REQ-028 cfg_sel changing while cfg_valid=0 has no effect.

Reset
REQ-029 Asserting reset (low) immediately forces: state IDLE, cnt 0, cur_sel 0, pending 0, clk_en 0, clk_out 0, busy 0, err 0, cfg_ready 1.
REQ-030 Reset asserted mid-period or mid-switch discards the pending request; release follows REQ-015.
REQ-031 err clears only by reset.

Structure
REQ-032 Package clk_div_pkg holds: the state enum, SEL_W=3, the default CNT_W, and a function computing N from a select.
REQ-033 One sub-module, clk_div_cnt, holds the counter, terminal decode and clk_out flop; clk_div_ctrl holds the FSM, handshake and pending register.

Verification
REQ-034 Reset release, run=1, cur_sel=0 -> clk_en high every 2nd cycle; clk_out toggles every cycle.
REQ-035 In RUN at sel=0, accept cfg_sel=2 -> busy=1, cfg_ready=0 until next terminal; then clk_en every 8 cycles and clk_out low 4 / high 4, with no pulse shorter than 1 cycle.
REQ-036 cfg_valid with cfg_sel=7 at CNT_W=8 -> accepted, cur_sel changes per REQ-021/022; cfg_sel=5 with CNT_W=4 -> err=1, cur_sel unchanged.
REQ-037 sel=1, run dropped mid-period -> exactly one further clk_en, then IDLE with clk_out=0 and busy=0.
REQ-038 Reset pulsed low during SWITCH -> all outputs at REQ-029 values in the same cycle; pending switch never applied.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
//
// Contents: FSM state encoding, select width, default counter width and
// a helper returning the divide ratio N = 2^(sel+1) for a select value.
package clk_div_pkg;

    localparam int SEL_W     = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Divide ratio for a select: N = 2^(sel+1).
    function automatic logic [31:0] div_ratio(input logic [SEL_W-1:0] sel);
        return 32'd1 << (32'(sel) + 32'd1);
    endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Divide counter with terminal decode and registered divided clock.
// Latency: clk_en/clk_out are flops computed from next-cycle count and select,
//          so they match the counter in the same cycle. No backpressure.
//
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   i_clr        : load counter with 0 on next edge (priority over i_inc)
//   i_inc        : increment counter (wraps modulo 2^CNT_W)
//   i_sel_nxt    : select that will be in effect next cycle
//   o_clk_en     : high in cycles where cnt[sel:0] is all ones
//   o_clk_out    : cnt[sel] for the current cycle
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [SEL_W-1:0] i_sel_nxt,
    output logic             o_clk_en,
    output logic             o_clk_out
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_mask;
    logic [CNT_W-1:0] w_shift;
    logic             r_clk_en;
    logic             r_clk_out;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Mask of the low (sel+1) bits; the select is always < CNT_W here.
    assign w_mask  = CNT_W'(div_ratio(i_sel_nxt) - 32'd1);
    // Shift instead of a variable bit-select so the index width never matters.
    assign w_shift = w_cnt_nxt >> i_sel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_en  <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_en  <= ((w_cnt_nxt & w_mask) == w_mask);
            r_clk_out <= w_shift[0];
        end
    end

    assign o_clk_en  = r_clk_en;
    assign o_clk_out = r_clk_out;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: FSM, ratio-change handshake and pending select.
// Latency: outputs registered; new ratio applied at the end of a full period.
// Backpressure: cfg_ready drops while a switch or stop is in progress.
//
// Ports:
//   clk, reset (async active-low), run (level: generate / graceful stop)
//   cfg_valid/cfg_sel/cfg_ready : ratio-change request, divide by 2^(sel+1)
//   clk_en (period pulse), clk_out (50% divided clock), cur_sel,
//   busy (switch/stop pending), err (sticky illegal select)
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             clk_en,
    output logic             clk_out,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [SEL_W-1:0] r_pend;
    logic [SEL_W-1:0] w_pend_nxt;
    logic             r_err;
    logic             w_hs;
    logic             w_illegal;
    logic             w_acc;
    logic             w_clr;
    logic             w_inc;
    logic             w_term;

    assign cfg_ready = (r_state == ST_IDLE) || (r_state == ST_RUN);
    assign busy      = (r_state == ST_SWITCH) || (r_state == ST_STOP);

    assign w_hs      = cfg_valid && cfg_ready;
    assign w_illegal = (32'(cfg_sel) >= 32'(CNT_W));
    assign w_acc     = w_hs && !w_illegal;

    // clk_en is registered to equal the terminal decode of the current
    // cycle, so it doubles as "this cycle ends a period".
    assign w_term    = clk_en;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_cur_sel;
        w_pend_nxt  = r_pend;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr = 1'b1;
                if (w_acc) begin
                    w_sel_nxt = cfg_sel;
                end
                if (run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_inc = 1'b1;
                // A legal request wins over run=0; the switch state itself
                // falls back to IDLE if run is low when it completes.
                if (w_acc) begin
                    w_pend_nxt  = cfg_sel;
                    w_state_nxt = ST_SWITCH;
                end else if (!run) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_SWITCH: begin
                if (w_term) begin
                    w_clr       = 1'b1;
                    w_sel_nxt   = r_pend;
                    w_state_nxt = run ? ST_RUN : ST_IDLE;
                end else begin
                    w_inc = 1'b1;
                end
            end
            ST_STOP: begin
                // run returning high does not abort the stop.
                if (w_term) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_inc = 1'b1;
                end
            end
            default: begin
                w_clr       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cur_sel <= '0;
            r_pend    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur_sel <= w_sel_nxt;
            r_pend    <= w_pend_nxt;
            if (w_hs && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cur_sel = r_cur_sel;
    assign err     = r_err;

    clk_div_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (reset),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .i_sel_nxt (w_sel_nxt),
        .o_clk_en  (clk_en),
        .o_clk_out (clk_out)
    );

endmodule
